// File: rtl/sensor_pattern_gen_if.sv
// Port bundle for sensor_pattern_gen: run control, frame timing configuration and the
// fval/lval/pixel stream. The master modport is the generator side.
interface sensor_pattern_gen_if #(
  parameter int DATA_WIDTH  = 12,
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_WIDTH   = 16
);
  logic                              i_pause_en;
  logic                              i_trigger_mode;
  logic                              i_trigger;
  logic [1:0]                        iv_pattern_sel;
  logic [CNT_WIDTH-1:0]              iv_width;
  logic [CNT_WIDTH-1:0]              iv_line_hide;
  logic [CNT_WIDTH-1:0]              iv_height;
  logic [CNT_WIDTH-1:0]              iv_frame_hide;
  logic [CNT_WIDTH-1:0]              iv_front_porch;
  logic [CNT_WIDTH-1:0]              iv_back_porch;
  logic                              o_fval;
  logic                              o_lval;
  logic [DATA_WIDTH*CHANNEL_NUM-1:0] ov_dout;
  logic [CNT_WIDTH-1:0]              ov_frame_cnt;
  logic                              o_frame_done;
  logic [2:0]                        dbg_state;

  // Stream semantics: there is no backpressure. Every clock with o_lval=1 carries one
  // valid word on ov_dout and the consumer must take it; o_fval brackets the lines of a
  // frame and ov_dout is forced to zero whenever o_lval=0.
  modport master (
    input  i_pause_en, i_trigger_mode, i_trigger, iv_pattern_sel,
    input  iv_width, iv_line_hide, iv_height, iv_frame_hide, iv_front_porch, iv_back_porch,
    output o_fval, o_lval, ov_dout, ov_frame_cnt, o_frame_done, dbg_state
  );

  modport slave (
    output i_pause_en, i_trigger_mode, i_trigger, iv_pattern_sel,
    output iv_width, iv_line_hide, iv_height, iv_frame_hide, iv_front_porch, iv_back_porch,
    input  o_fval, o_lval, ov_dout, ov_frame_cnt, o_frame_done, dbg_state
  );
endinterface

// File: rtl/sensor_pattern_gen.sv
// Sensor output generator: fval/lval frame timing plus multi-channel test patterns,
// free-running or one frame per trigger, all outputs registered.
module sensor_pattern_gen #(
  parameter int DATA_WIDTH  = 12,
  parameter int CHANNEL_NUM = 4,
  parameter int CNT_WIDTH   = 16
) (
  input  logic                 clk,
  input  logic                 reset_n,
  sensor_pattern_gen_if.master bus
);
  localparam int DOUT_W = DATA_WIDTH * CHANNEL_NUM;
  localparam logic [CNT_WIDTH-1:0] ZERO = '0;
  localparam logic [CNT_WIDTH-1:0] ONE  = CNT_WIDTH'(1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_FRONT = 3'd1,
    S_LINE  = 3'd2,
    S_HIDE  = 3'd3,
    S_BACK  = 3'd4,
    S_FHIDE = 3'd5
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] line_q, line_d;
  logic [CNT_WIDTH-1:0] pix_q, pix_d;
  logic [CNT_WIDTH-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_WIDTH-1:0] width_q, width_d, line_hide_q, line_hide_d, height_q, height_d;
  logic [CNT_WIDTH-1:0] frame_hide_q, frame_hide_d, front_q, front_d, back_q, back_d;
  logic [1:0]           sel_q, sel_d;
  logic                 trig_prev_q, trig_prev_d;
  logic                 fval_q, fval_d, lval_q, lval_d, done_q, done_d;
  logic [DOUT_W-1:0]    dout_q, dout_d;

  logic                 in_idle, trig_edge, start, enter_fhide;
  logic [CNT_WIDTH-1:0] w_width, w_line_hide, w_height, w_frame_hide, w_front, w_back;
  logic [1:0]           w_sel;
  logic [CNT_WIDTH-1:0] px;
  logic [DATA_WIDTH-1:0] pixel;

  // In IDLE the live inputs are the working config (they are what gets latched on the
  // start decision); everywhere else the frame runs from the shadow copy.
  always_comb begin
    in_idle      = (state_q == S_IDLE);
    trig_edge    = bus.i_trigger & ~trig_prev_q;
    trig_prev_d  = bus.i_trigger;
    start        = in_idle & ~bus.i_pause_en & (bus.iv_width != ZERO) &
                   (bus.iv_height != ZERO) & (~bus.i_trigger_mode | trig_edge);
    w_width      = in_idle ? bus.iv_width       : width_q;
    w_line_hide  = in_idle ? bus.iv_line_hide   : line_hide_q;
    w_height     = in_idle ? bus.iv_height      : height_q;
    w_frame_hide = in_idle ? bus.iv_frame_hide  : frame_hide_q;
    w_front      = in_idle ? bus.iv_front_porch : front_q;
    w_back       = in_idle ? bus.iv_back_porch  : back_q;
    w_sel        = in_idle ? bus.iv_pattern_sel : sel_q;
    width_d      = start ? bus.iv_width       : width_q;
    line_hide_d  = start ? bus.iv_line_hide   : line_hide_q;
    height_d     = start ? bus.iv_height      : height_q;
    frame_hide_d = start ? bus.iv_frame_hide  : frame_hide_q;
    front_d      = start ? bus.iv_front_porch : front_q;
    back_d       = start ? bus.iv_back_porch  : back_q;
    sel_d        = start ? bus.iv_pattern_sel : sel_q;
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    line_d      = line_q;
    pix_d       = pix_q;
    frame_cnt_d = frame_cnt_q;
    enter_fhide = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          line_d = ZERO;
          pix_d  = ZERO;
          if (w_front != ZERO) begin
            state_d = S_FRONT;
            cnt_d   = w_front - ONE;
          end else begin
            state_d = S_LINE;
            cnt_d   = w_width - ONE;
          end
        end
      end
      S_FRONT: begin
        if (cnt_q == ZERO) begin
          state_d = S_LINE;
          cnt_d   = w_width - ONE;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_LINE: begin
        if (cnt_q != ZERO) begin
          cnt_d = cnt_q - ONE;
          pix_d = pix_q + ONE;
        end else if (line_q == w_height - ONE) begin
          if (w_back != ZERO) begin
            state_d = S_BACK;
            cnt_d   = w_back - ONE;
          end else begin
            enter_fhide = 1'b1;
          end
        end else if (w_line_hide != ZERO) begin
          state_d = S_HIDE;
          cnt_d   = w_line_hide - ONE;
        end else begin
          // Zero line blanking: lval stays high, only the line/pixel counters move on.
          cnt_d  = w_width - ONE;
          line_d = line_q + ONE;
          pix_d  = ZERO;
        end
      end
      S_HIDE: begin
        if (cnt_q == ZERO) begin
          state_d = S_LINE;
          cnt_d   = w_width - ONE;
          line_d  = line_q + ONE;
          pix_d   = ZERO;
        end else begin
          cnt_d = cnt_q - ONE;
        end
      end
      S_BACK: begin
        if (cnt_q == ZERO) enter_fhide = 1'b1;
        else               cnt_d = cnt_q - ONE;
      end
      S_FHIDE: begin
        if (cnt_q == ZERO) state_d = S_IDLE;
        else               cnt_d = cnt_q - ONE;
      end
      default: state_d = S_IDLE;
    endcase
    if (enter_fhide) begin
      state_d     = S_FHIDE;
      cnt_d       = (w_frame_hide == ZERO) ? ZERO : w_frame_hide - ONE;
      frame_cnt_d = frame_cnt_q + ONE;
    end
  end

  // Outputs are derived from the next state so they land on the same edge as the state.
  always_comb begin
    fval_d = (state_d == S_FRONT) || (state_d == S_LINE) ||
             (state_d == S_HIDE)  || (state_d == S_BACK);
    lval_d = (state_d == S_LINE);
    done_d = enter_fhide;
    dout_d = '0;
    px     = ZERO;
    pixel  = '0;
    if (lval_d) begin
      for (int k = 0; k < CHANNEL_NUM; k++) begin
        px = pix_d * CNT_WIDTH'(CHANNEL_NUM) + CNT_WIDTH'(k);
        case (w_sel)
          2'd0:    pixel = DATA_WIDTH'(line_d);
          2'd1:    pixel = DATA_WIDTH'(px);
          2'd2:    pixel = DATA_WIDTH'(frame_cnt_d);
          default: pixel = (line_d[0] ^ px[0]) ? '1 : '0;
        endcase
        dout_d[k*DATA_WIDTH +: DATA_WIDTH] = pixel;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      line_q       <= '0;
      pix_q        <= '0;
      frame_cnt_q  <= '0;
      width_q      <= '0;
      line_hide_q  <= '0;
      height_q     <= '0;
      frame_hide_q <= '0;
      front_q      <= '0;
      back_q       <= '0;
      sel_q        <= '0;
      trig_prev_q  <= 1'b0;
      fval_q       <= 1'b0;
      lval_q       <= 1'b0;
      done_q       <= 1'b0;
      dout_q       <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      line_q       <= line_d;
      pix_q        <= pix_d;
      frame_cnt_q  <= frame_cnt_d;
      width_q      <= width_d;
      line_hide_q  <= line_hide_d;
      height_q     <= height_d;
      frame_hide_q <= frame_hide_d;
      front_q      <= front_d;
      back_q       <= back_d;
      sel_q        <= sel_d;
      trig_prev_q  <= trig_prev_d;
      fval_q       <= fval_d;
      lval_q       <= lval_d;
      done_q       <= done_d;
      dout_q       <= dout_d;
    end
  end

  assign bus.o_fval       = fval_q;
  assign bus.o_lval       = lval_q;
  assign bus.ov_dout      = dout_q;
  assign bus.ov_frame_cnt = frame_cnt_q;
  assign bus.o_frame_done = done_q;
  assign bus.dbg_state    = state_q;
endmodule

// File: tb/tb_sensor_pattern_gen.sv
// Bench for sensor_pattern_gen: frame-level reference model checked every clock, plus
// directed timing/pattern/trigger/pause/reset scenarios with literal expectations.
`timescale 1ns/1ps
module tb_sensor_pattern_gen;
  localparam int DW     = 12;
  localparam int CH     = 4;
  localparam int CW     = 16;
  localparam int DOUT_W = DW * CH;
  localparam int EXP_W  = 3 + DOUT_W + CW;

  logic clk     = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  sensor_pattern_gen_if #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CNT_WIDTH(CW)) bus ();
  sensor_pattern_gen #(.DATA_WIDTH(DW), .CHANNEL_NUM(CH), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks   = 0;
  int failures = 0;

  // Expected per-clock output words: {fval, lval, done, dout, frame_cnt}.
  logic [EXP_W-1:0] exp_q[$];
  logic [EXP_W-1:0] cur_exp;
  int unsigned      m_fcnt      = 0;
  logic             m_prev_trig = 1'b0;
  logic             model_en    = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [EXP_W-1:0] mk(input logic f, input logic l,
                                          input logic [DOUT_W-1:0] d,
                                          input int unsigned fc, input logic dn);
    logic [CW-1:0] fcw;
    fcw = fc[CW-1:0];
    return {f, l, dn, d, fcw};
  endfunction

  function automatic logic [DOUT_W-1:0] pix_word(input int sel, input int line,
                                                 input int p, input int unsigned fc);
    logic [DOUT_W-1:0] w;
    w = '0;
    for (int k = 0; k < CH; k++) begin
      int x;
      int v;
      x = p * CH + k;
      case (sel)
        0:       v = line;
        1:       v = x;
        2:       v = int'(fc);
        default: v = (((line ^ x) & 1) != 0) ? -1 : 0;
      endcase
      w[k*DW +: DW] = v[DW-1:0];
    end
    return w;
  endfunction

  task automatic push_frame(input int w, input int lh, input int h, input int fh,
                            input int fr, input int bk, input int sel);
    int unsigned fc;
    fc = m_fcnt;
    for (int i = 0; i < fr; i++) exp_q.push_back(mk(1'b1, 1'b0, '0, fc, 1'b0));
    for (int l = 0; l < h; l++) begin
      for (int p = 0; p < w; p++) exp_q.push_back(mk(1'b1, 1'b1, pix_word(sel, l, p, fc), fc, 1'b0));
      if (l != h - 1)
        for (int i = 0; i < lh; i++) exp_q.push_back(mk(1'b1, 1'b0, '0, fc, 1'b0));
    end
    for (int i = 0; i < bk; i++) exp_q.push_back(mk(1'b1, 1'b0, '0, fc, 1'b0));
    m_fcnt = (m_fcnt + 1) % 65536;
    for (int i = 0; i < ((fh == 0) ? 1 : fh); i++)
      exp_q.push_back(mk(1'b0, 1'b0, '0, m_fcnt, (i == 0)));
    exp_q.push_back(mk(1'b0, 1'b0, '0, m_fcnt, 1'b0));
  endtask

  task automatic model_step();
    logic edge_s;
    edge_s      = bus.i_trigger & ~m_prev_trig;
    m_prev_trig = bus.i_trigger;
    if (exp_q.size() == 0 && !bus.i_pause_en && bus.iv_width != 0 && bus.iv_height != 0 &&
        (!bus.i_trigger_mode || edge_s))
      push_frame(int'(bus.iv_width), int'(bus.iv_line_hide), int'(bus.iv_height),
                 int'(bus.iv_frame_hide), int'(bus.iv_front_porch), int'(bus.iv_back_porch),
                 int'(bus.iv_pattern_sel));
    if (exp_q.size() != 0) cur_exp = exp_q.pop_front();
    else                   cur_exp = mk(1'b0, 1'b0, '0, m_fcnt, 1'b0);
  endtask

  task automatic model_reset();
    exp_q.delete();
    m_fcnt      = 0;
    m_prev_trig = 1'b0;
  endtask

  always @(posedge clk) begin
    if (model_en) begin
      model_step();
      #1;
      check("fval",      64'(bus.o_fval),       64'(cur_exp[EXP_W-1]));
      check("lval",      64'(bus.o_lval),       64'(cur_exp[EXP_W-2]));
      check("done",      64'(bus.o_frame_done), 64'(cur_exp[EXP_W-3]));
      check("dout",      64'(bus.ov_dout),      64'(cur_exp[EXP_W-4 -: DOUT_W]));
      check("frame_cnt", 64'(bus.ov_frame_cnt), 64'(cur_exp[CW-1:0]));
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_cfg(input int w, input int lh, input int h, input int fh,
                         input int fr, input int bk, input int sel);
    bus.iv_width       = CW'(w);
    bus.iv_line_hide   = CW'(lh);
    bus.iv_height      = CW'(h);
    bus.iv_frame_hide  = CW'(fh);
    bus.iv_front_porch = CW'(fr);
    bus.iv_back_porch  = CW'(bk);
    bus.iv_pattern_sel = 2'(sel);
  endtask

  task automatic window(input int n, output int fv, output int lv, output int dn,
                        output int hi_max, output int lo_max, output int mis);
    int hi;
    int lo;
    hi = 0; lo = 0; fv = 0; lv = 0; dn = 0; hi_max = 0; lo_max = 0; mis = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      fv += int'(bus.o_fval);
      lv += int'(bus.o_lval);
      dn += int'(bus.o_frame_done);
      if (bus.o_fval != bus.o_lval) mis++;
      if (bus.o_fval) begin hi++; lo = 0; end
      else            begin lo++; hi = 0; end
      if (hi > hi_max) hi_max = hi;
      if (lo > lo_max) lo_max = lo;
    end
  endtask

  task automatic drain();
    int quiet;
    quiet = 0;
    bus.i_pause_en = 1'b1;
    for (int i = 0; i < 200 && quiet < 30; i++) begin
      tick();
      quiet = bus.o_fval ? 0 : quiet + 1;
    end
    check("drain_idle", 64'(quiet >= 30), 64'(1));
  endtask

  task automatic wait_rise(input string name);
    logic prev;
    logic seen;
    prev = bus.o_fval;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      tick();
      if (bus.o_fval && !prev) seen = 1'b1;
      prev = bus.o_fval;
    end
    check(name, 64'(seen), 64'(1));
  endtask

  initial begin
    int fv, lv, dn, hi_max, lo_max, mis, got, zero_bad;
    logic [DOUT_W-1:0] words[2];
    logic [DOUT_W-1:0] exp_w0, exp_w1;

    bus.i_pause_en     = 1'b1;
    bus.i_trigger_mode = 1'b0;
    bus.i_trigger      = 1'b0;
    set_cfg(0, 0, 0, 0, 0, 0, 0);

    // Reset state
    repeat (3) tick();
    check("rst_fval",  64'(bus.o_fval),       64'(0));
    check("rst_lval",  64'(bus.o_lval),       64'(0));
    check("rst_dout",  64'(bus.ov_dout),      64'(0));
    check("rst_fcnt",  64'(bus.ov_frame_cnt), 64'(0));
    check("rst_done",  64'(bus.o_frame_done), 64'(0));
    reset_n = 1'b1;
    model_reset();
    model_en = 1'b1;

    // Basic free-run timing: 19 clk fval high, 6 clk low, three frames in 75 clk
    set_cfg(4, 2, 3, 5, 1, 2, 0);
    bus.i_pause_en = 1'b0;
    window(75, fv, lv, dn, hi_max, lo_max, mis);
    check("t1_fval_run",   64'(hi_max), 64'(19));
    check("t1_fval_low",   64'(lo_max), 64'(6));
    check("t1_fval_total", 64'(fv),     64'(57));
    check("t1_lval_total", 64'(lv),     64'(36));
    check("t1_done_cnt",   64'(dn),     64'(3));
    check("t1_frame_cnt",  64'(bus.ov_frame_cnt), 64'(3));

    // PIX_INC packing, channel 0 in the LSBs
    drain();
    set_cfg(2, 1, 2, 2, 1, 1, 1);
    bus.i_pause_en = 1'b0;
    got = 0; zero_bad = 0;
    words[0] = '0; words[1] = '0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.o_lval && got < 2) begin words[got] = bus.ov_dout; got++; end
      if (!bus.o_lval && bus.ov_dout != '0) zero_bad++;
    end
    exp_w0 = 48'h003_002_001_000;
    exp_w1 = 48'h007_006_005_004;
    check("t2_word0",     64'(words[0]), 64'(exp_w0));
    check("t2_word1",     64'(words[1]), 64'(exp_w1));
    check("t2_dout_zero", 64'(zero_bad), 64'(0));

    // No porches, no line blanking: fval and lval coincide
    drain();
    set_cfg(3, 0, 2, 20, 0, 0, 3);
    bus.i_pause_en = 1'b0;
    window(26, fv, lv, dn, hi_max, lo_max, mis);
    check("t5_lval_total", 64'(lv),  64'(6));
    check("t5_fval_lval",  64'(mis), 64'(0));
    check("t5_done",       64'(dn),  64'(1));

    // Triggered mode: mid-frame edges are dropped
    drain();
    set_cfg(4, 2, 3, 5, 1, 2, 2);
    bus.i_trigger_mode = 1'b1;
    bus.i_pause_en     = 1'b0;
    window(10, fv, lv, dn, hi_max, lo_max, mis);
    check("t3_no_trig_fval", 64'(fv), 64'(0));
    fv = 0; dn = 0;
    for (int i = 0; i < 80; i++) begin
      bus.i_trigger = (i == 0 || i == 8 || i == 11 || i == 40 || i == 47);
      tick();
      fv += int'(bus.o_fval);
      dn += int'(bus.o_frame_done);
    end
    bus.i_trigger = 1'b0;
    check("t3_fval_total", 64'(fv), 64'(38));
    check("t3_done_cnt",   64'(dn), 64'(2));

    // Pause mid-frame finishes the frame then holds
    bus.i_trigger_mode = 1'b0;
    wait_rise("t4_start");
    fv = 1;
    for (int i = 0; i < 4; i++) begin tick(); fv += int'(bus.o_fval); end
    bus.i_pause_en = 1'b1;
    window(60, lv, mis, dn, hi_max, lo_max, got);
    check("t4_fval_total", 64'(fv + lv), 64'(19));
    check("t4_done",       64'(dn),      64'(1));
    check("t4_held_low",   64'(bus.o_fval), 64'(0));
    bus.i_pause_en = 1'b0;
    wait_rise("t4_resume");

    // Asynchronous reset during line 1
    repeat (8) tick();
    check("t6_pre_lval", 64'(bus.o_lval), 64'(1));
    model_en = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_fval", 64'(bus.o_fval),       64'(0));
    check("t6_lval", 64'(bus.o_lval),       64'(0));
    check("t6_dout", 64'(bus.ov_dout),      64'(0));
    check("t6_fcnt", 64'(bus.ov_frame_cnt), 64'(0));
    check("t6_done", 64'(bus.o_frame_done), 64'(0));
    repeat (3) tick();
    reset_n = 1'b1;
    model_reset();
    model_en = 1'b1;
    wait_rise("t6_restart");
    check("t6_restart_fcnt", 64'(bus.ov_frame_cnt), 64'(0));

    // Randomised run with mid-frame config changes, pause and trigger activity
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 29) == 0)
        set_cfg(int'($urandom_range(0, 5)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                int'($urandom_range(0, 3)));
      if ($urandom_range(0, 49) == 0)  bus.i_pause_en     = ~bus.i_pause_en;
      if ($urandom_range(0, 199) == 0) bus.i_trigger_mode = ~bus.i_trigger_mode;
      bus.i_trigger = ($urandom_range(0, 5) == 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
